bcrypt_ctext: RTL and testbench

Final bcrypt stage, directly downstream of the key-expansion/cost loop. Once the P-array and S-boxes hold the expensive-setup state, this block encrypts the 192-bit magic string "OrpheanBeholderScryDoubt" ROUNDS times in ECB mode and presents the 192-bit hash. It owns no SRAM port. Each block encipher is requested through the shared feistel start/done handshake, and the parent muxes the feistel core between expand-key and this block.

---
 rtl/bcrypt_ctext_pkg.sv | 17 +
 rtl/bcrypt_ctext_if.sv | 30 +++
 rtl/bcrypt_ctext.sv | 105 ++++++++++
 tb/tb_bcrypt_ctext.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcrypt_ctext_pkg.sv
// Shared types and constants for the bcrypt final ctext stage.
// Holds the FSM state enum, the magic string and the 64-bit block type.
package bcrypt_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        FINISH
    } state_t;

    localparam logic [191:0] BCRYPT_MAGIC =
        192'h4F727068_65616E42_65686F6C_64657253_63727944_6F756274;

    typedef logic [63:0] block_t;

endpackage

// File: rtl/bcrypt_ctext_if.sv
// Start/done handshake to the shared feistel core.
// The ctext stage drives requests through the master side.
interface bcrypt_ctext_if;

    logic        fs_start;
    logic [31:0] fs_L;
    logic [31:0] fs_R;
    logic        fs_done;
    logic [31:0] fs_resultL;
    logic [31:0] fs_resultR;

    modport master (
        output fs_start,
        output fs_L,
        output fs_R,
        input  fs_done,
        input  fs_resultL,
        input  fs_resultR
    );

    modport slave (
        input  fs_start,
        input  fs_L,
        input  fs_R,
        output fs_done,
        output fs_resultL,
        output fs_resultR
    );

endinterface

// File: rtl/bcrypt_ctext.sv
// bcrypt final stage: ECB-encrypts the magic string ROUNDS times.
// Option BCRYPT_CTEXT_TRUNC_EN zeroes hash[7:0] for the 23-byte output.
module bcrypt_ctext
    import bcrypt_pkg::*;
#(
    parameter int           ROUNDS = 64,
    parameter logic [191:0] MAGIC  = BCRYPT_MAGIC
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [191:0]   hash,
    bcrypt_ctext_if.master fs
);

    localparam logic [7:0] LAST = 8'(ROUNDS - 1);

    state_t     state;
    block_t     ctext [3];
    logic [1:0] blk;
    logic [7:0] round;

    logic [1:0] nxt_blk;
    block_t     nxt_ct;

    assign nxt_blk = (blk == 2'd2) ? 2'd0 : blk + 2'd1;

    // Next block differs from blk, so its ctext is not being rewritten now.
    always_comb begin
        nxt_ct = ctext[0];
        unique case (nxt_blk)
            2'd1:    nxt_ct = ctext[1];
            2'd2:    nxt_ct = ctext[2];
            default: nxt_ct = ctext[0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            hash        <= '0;
            fs.fs_start <= 1'b0;
            fs.fs_L     <= '0;
            fs.fs_R     <= '0;
            blk         <= '0;
            round       <= '0;
            for (int i = 0; i < 3; i++) ctext[i] <= '0;
        end else begin
            done        <= 1'b0;
            fs.fs_start <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        ctext[0]    <= MAGIC[191:128];
                        ctext[1]    <= MAGIC[127:64];
                        ctext[2]    <= MAGIC[63:0];
                        blk         <= '0;
                        round       <= '0;
                        fs.fs_start <= 1'b1;
                        fs.fs_L     <= MAGIC[191:160];
                        fs.fs_R     <= MAGIC[159:128];
                        busy        <= 1'b1;
                        state       <= ISSUE;
                    end
                end
                ISSUE: state <= WAIT;
                WAIT: begin
                    if (fs.fs_done) begin
                        ctext[blk] <= {fs.fs_resultL, fs.fs_resultR};
                        if (blk == 2'd2 && round == LAST) begin
                            state <= FINISH;
                        end else begin
                            if (blk == 2'd2) begin
                                blk   <= '0;
                                round <= round + 8'd1;
                            end else begin
                                blk <= blk + 2'd1;
                            end
                            fs.fs_start <= 1'b1;
                            fs.fs_L     <= nxt_ct[63:32];
                            fs.fs_R     <= nxt_ct[31:0];
                            state       <= ISSUE;
                        end
                    end
                end
                FINISH: begin
`ifdef BCRYPT_CTEXT_TRUNC_EN
                    hash <= {ctext[0], ctext[1], ctext[2][63:8], 8'h00};
`else
                    hash <= {ctext[0], ctext[1], ctext[2]};
`endif
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcrypt_ctext.sv
// Self-checking bench for bcrypt_ctext: vector table, corner sequences
// and randomized feistel keys against an iterative reference model.
module tb_bcrypt_ctext;
    import bcrypt_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         start0, start1;
    logic         busy0, busy1, done0, done1;
    logic [191:0] hash0, hash1;

    bcrypt_ctext_if f0();
    bcrypt_ctext_if f1();

    bcrypt_ctext #(.ROUNDS(64)) u0 (
        .clk(clk), .reset(rst_n), .start(start0), .busy(busy0),
        .done(done0), .hash(hash0), .fs(f0)
    );

    bcrypt_ctext #(.ROUNDS(1)) u1 (
        .clk(clk), .reset(rst_n), .start(start1), .busy(busy1),
        .done(done1), .hash(hash1), .fs(f1)
    );

    // One feistel model serves both DUTs; only one runs at a time.
    logic        m_done = 1'b0;
    logic [31:0] m_l = '0;
    logic [31:0] m_r = '0;

    assign f0.fs_done    = m_done;
    assign f0.fs_resultL = m_l;
    assign f0.fs_resultR = m_r;
    assign f1.fs_done    = m_done;
    assign f1.fs_resultL = m_l;
    assign f1.fs_resultR = m_r;

    int          cfg_mode = 0;
    int          cfg_tf = 1;
    bit          cfg_spur = 1'b0;
    logic [31:0] k0 = '0;
    logic [31:0] k1 = '0;
    int          req = 0;
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;

    always @(posedge clk) cyc++;

    function automatic logic [63:0] fmodel(input logic [31:0] l,
                                           input logic [31:0] r,
                                           input int mode);
        case (mode)
            0:       return {r, l};
            1:       return {l + 32'd1, r};
            default: return {r ^ k0, l + k1};
        endcase
    endfunction

    int          m_cnt = 0;
    bit          m_pend = 1'b0;
    bit          m_last = 1'b0;
    logic [31:0] cap_l, cap_r;

    always @(posedge clk) begin
        m_done <= 1'b0;
        if (!rst_n) begin
            m_pend = 1'b0;
            m_last = 1'b0;
        end else begin
            if (cfg_spur && m_last) begin
                m_done <= 1'b1;
                m_l    <= 32'hDEADBEEF;
                m_r    <= 32'h0BADF00D;
            end
            m_last = 1'b0;
            if (f0.fs_start || f1.fs_start) begin
                req++;
                cap_l  = f0.fs_start ? f0.fs_L : f1.fs_L;
                cap_r  = f0.fs_start ? f0.fs_R : f1.fs_R;
                m_cnt  = cfg_tf;
                m_pend = 1'b1;
            end
            if (m_pend) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_pend = 1'b0;
                    m_last = 1'b1;
                    {m_l, m_r} <= fmodel(cap_l, cap_r, cfg_mode);
                    m_done <= 1'b1;
                end
            end
        end
    end

    function automatic logic [191:0] trunc(input logic [191:0] h);
        logic [191:0] t;
        t = h;
`ifdef BCRYPT_CTEXT_TRUNC_EN
        t[7:0] = 8'h00;
`endif
        return t;
    endfunction

    // Reference: apply the cipher to the three magic blocks, round by round.
    function automatic logic [191:0] ref_hash(input int rounds,
                                              input int mode);
        logic [191:0] m;
        logic [31:0]  w [6];
        logic [63:0]  o;
        m = BCRYPT_MAGIC;
        for (int i = 0; i < 6; i++) w[i] = m[191 - 32*i -: 32];
        for (int r = 0; r < rounds; r++)
            for (int b = 0; b < 3; b++) begin
                o = fmodel(w[2*b], w[2*b+1], mode);
                w[2*b]   = o[63:32];
                w[2*b+1] = o[31:0];
            end
        return trunc({w[0], w[1], w[2], w[3], w[4], w[5]});
    endfunction

    task automatic chk(input string name, input logic [191:0] act,
                       input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic run(input int sel, input int mode, input int tf,
                       input bit spur, input bit hold,
                       output int lat, output logic [191:0] h,
                       output int nd, output int nreq,
                       output logic busy_after);
        int t0, r0;
        bit seen;
        cfg_mode = mode;
        cfg_tf   = tf;
        cfg_spur = spur;
        @(negedge clk);
        r0 = req;
        t0 = cyc;
        if (sel == 0) start0 = 1'b1;
        else start1 = 1'b1;
        seen = 1'b0;
        nd   = 0;
        lat  = -1;
        h    = '0;
        for (int k = 0; k < 6000 && !seen; k++) begin
            @(negedge clk);
            if (!hold) begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if ((sel == 0) ? done0 : done1) begin
                seen   = 1'b1;
                nd     = 1;
                lat    = cyc - t0;
                h      = (sel == 0) ? hash0 : hash1;
                start0 = 1'b0;
                start1 = 1'b0;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL timeout sel=%0d waiting for done", sel);
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if ((sel == 0) ? done0 : done1) nd++;
        end
        busy_after = (sel == 0) ? busy0 : busy1;
        nreq = req - r0;
        cfg_spur = 1'b0;
    endtask

    typedef struct {
        int           sel;
        int           mode;
        int           tf;
        bit           spur;
        bit           hold;
        logic [191:0] h;
        int           lat;
        int           nreq;
    } vec_t;

    vec_t tbl [5];

    initial begin
        int           lat, nd, nreq, r0, rounds, sel, tf;
        logic [191:0] h;
        logic         ba;
        bit           hit;

        tbl[0] = '{0, 0, 3, 0, 0, BCRYPT_MAGIC, 770, 192};
        tbl[1] = '{0, 1, 1, 0, 0,
            192'h4F7270A8_65616E42_65686FAC_64657253_63727984_6F756274,
            386, 192};
        tbl[2] = '{1, 1, 1, 0, 0,
            192'h4F727069_65616E42_65686F6D_64657253_63727945_6F756274,
            8, 3};
        tbl[3] = '{1, 0, 2, 0, 0,
            192'h65616E42_4F727068_64657253_65686F6C_6F756274_63727944,
            11, 3};
        tbl[4] = '{0, 0, 3, 1, 1, BCRYPT_MAGIC, 770, 192};

        rst_n  = 1'b0;
        start0 = 1'b0;
        start1 = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 192'(busy0), 192'd0);
        chk("rst_done", 192'(done0), 192'd0);
        chk("rst_hash", hash0, 192'd0);
        chk("rst_fs_start", 192'(f0.fs_start), 192'd0);
        chk("rst_fs_L", 192'(f0.fs_L), 192'd0);
        chk("rst_fs_R", 192'(f0.fs_R), 192'd0);
        chk("rst_busy1", 192'(busy1), 192'd0);

        for (int i = 0; i < 5; i++) begin
            run(tbl[i].sel, tbl[i].mode, tbl[i].tf, tbl[i].spur,
                tbl[i].hold, lat, h, nd, nreq, ba);
            chk($sformatf("v%0d_hash", i), h, trunc(tbl[i].h));
            chk($sformatf("v%0d_lat", i), 192'(lat), 192'(tbl[i].lat));
            chk($sformatf("v%0d_req", i), 192'(nreq), 192'(tbl[i].nreq));
            chk($sformatf("v%0d_ndone", i), 192'(nd), 192'd1);
            chk($sformatf("v%0d_idle", i), 192'(ba), 192'd0);
        end

        // Reset in the middle of a run, coinciding with fs_done.
        cfg_mode = 1;
        cfg_tf   = 1;
        @(negedge clk);
        r0 = req;
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 2000 && !hit; k++) begin
            if (req - r0 == 100) hit = 1'b1;
            else @(negedge clk);
        end
        chk("rst_mid_reach100", 192'(hit), 192'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_mid_busy", 192'(busy0), 192'd0);
        chk("rst_mid_fs_start", 192'(f0.fs_start), 192'd0);
        chk("rst_mid_hash", hash0, 192'd0);
        chk("rst_mid_done", 192'(done0), 192'd0);
        rst_n = 1'b1;
        @(negedge clk);
        run(0, 1, 1, 1'b0, 1'b0, lat, h, nd, nreq, ba);
        chk("rst_rerun_hash", h, trunc(tbl[1].h));
        chk("rst_rerun_req", 192'(nreq), 192'd192);

        // start kept high across done restarts on the following cycle.
        cfg_mode = 1;
        cfg_tf   = 1;
        @(negedge clk);
        start1 = 1'b1;
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (done1) hit = 1'b1;
        end
        chk("restart_done_seen", 192'(hit), 192'd1);
        chk("restart_busy_low", 192'(busy1), 192'd0);
        @(negedge clk);
        start1 = 1'b0;
        chk("restart_busy_high", 192'(busy1), 192'd1);
        chk("restart_fs_start", 192'(f1.fs_start), 192'd1);
        hit = 1'b0;
        for (int k = 0; k < 100 && !hit; k++) begin
            @(negedge clk);
            if (done1) hit = 1'b1;
        end
        chk("restart_hash", hash1, trunc(tbl[2].h));

        for (int i = 0; i < 6; i++) begin
            sel    = int'($urandom_range(0, 1));
            tf     = int'($urandom_range(1, 4));
            k0     = $urandom;
            k1     = $urandom;
            rounds = (sel == 0) ? 64 : 1;
            run(sel, 2, tf, 1'b0, 1'b0, lat, h, nd, nreq, ba);
            chk($sformatf("rnd%0d_hash", i), h, ref_hash(rounds, 2));
            chk($sformatf("rnd%0d_lat", i), 192'(lat),
                192'(3 * rounds * (tf + 1) + 2));
            chk($sformatf("rnd%0d_req", i), 192'(nreq), 192'(3 * rounds));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
